line_window_buf: RTL and testbench

//  Parametrised multi-row line buffer for raster pixel streams; successor to the per-row 512x8 dual-port line RAM.

---
 rtl/line_window_buf_pkg.sv | 19 +
 rtl/line_window_buf_ram_rbw.sv | 26 ++
 rtl/line_window_buf.sv | 110 +++++++++++
 tb/tb_line_window_buf.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/line_window_buf_pkg.sv
// Shared defaults and index helpers for the multi-row line window buffer.
package line_buf_pkg;

   localparam int DW_DEF      = 8;
   localparam int IMG_W_DEF   = 512;
   localparam int N_LINES_DEF = 3;

   // $clog2 that never yields a zero-width vector
   function automatic int clog2_safe(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // RAM holding the row k lines above the one being written; k == m maps back onto line
   function automatic int unsigned tap_idx(input int unsigned line, input int unsigned k,
                                           input int unsigned m);
      return (line + m - k) % m;
   endfunction

endpackage

// File: rtl/line_window_buf_ram_rbw.sv
// Single-clock column RAM; registered read returns the old word when written in the same cycle.
module line_ram_rbw
   import line_buf_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DEPTH = IMG_W_DEF,
   parameter int AW    = clog2_safe(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] di,
   output logic [DW-1:0] dout
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         dout <= mem[addr];
         if (we) mem[addr] <= di;
      end
   end

endmodule

// File: rtl/line_window_buf.sv
// Multi-row line buffer: emits one vertical column of N_LINES pixels per accepted input pixel.
module line_window_buf
   import line_buf_pkg::*;
#(
   parameter  int DW      = DW_DEF,
   parameter  int IMG_W   = IMG_W_DEF,
   parameter  int N_LINES = N_LINES_DEF,
   localparam int AW      = clog2_safe(IMG_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  sof,
   input  logic                  pix_valid,
   input  logic [DW-1:0]         pix_in,
   output logic                  out_valid,
   output logic [N_LINES*DW-1:0] win_col,
   output logic [AW-1:0]         out_col,
   output logic                  out_eol,
   output logic                  out_full
);

   localparam int unsigned M  = N_LINES - 1;
   localparam int          LW = clog2_safe(M);
   localparam int          FW = clog2_safe(M + 1);
   localparam logic [AW-1:0] LAST_COL  = AW'(IMG_W - 1);
   localparam logic [LW-1:0] LAST_LINE = LW'(M - 1);
   localparam logic [FW-1:0] FILL_MAX  = FW'(M);

   logic [AW-1:0] col_cnt, cur_col;
   logic [LW-1:0] wr_line, cur_line, sel_line;
   logic [FW-1:0] fill_cnt, cur_fill;
   logic          accept, restart, live;
   logic [DW-1:0] tap0;
   logic [DW-1:0] rd [M];

   // sof restarts the position for the very pixel it accompanies
   always_comb begin
      accept   = pix_valid & rst_n;
      restart  = accept & sof;
      cur_col  = restart ? '0 : col_cnt;
      cur_line = restart ? '0 : wr_line;
      cur_fill = restart ? '0 : fill_cnt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col_cnt  <= '0;
         wr_line  <= '0;
         fill_cnt <= '0;
      end else if (accept) begin
         if (cur_col == LAST_COL) begin
            col_cnt  <= '0;
            wr_line  <= (cur_line == LAST_LINE) ? '0 : cur_line + 1'b1;
            fill_cnt <= (cur_fill == FILL_MAX) ? FILL_MAX : cur_fill + 1'b1;
         end else begin
            col_cnt  <= cur_col + 1'b1;
            wr_line  <= cur_line;
            fill_cnt <= cur_fill;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_eol   <= 1'b0;
         out_full  <= 1'b0;
         out_col   <= '0;
         tap0      <= '0;
         sel_line  <= '0;
         live      <= 1'b0;
      end else begin
         out_valid <= accept;
         if (accept) begin
            tap0     <= pix_in;
            out_col  <= cur_col;
            out_eol  <= (cur_col == LAST_COL);
            out_full <= (cur_fill == FILL_MAX);
            sel_line <= cur_line;
            live     <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < M; i++) begin : g_ram
      line_ram_rbw #(.DW(DW), .DEPTH(IMG_W), .AW(AW)) u_ram (
         .clk  (clk),
         .en   (accept),
         .we   (cur_line == LW'(i)),
         .addr (cur_col),
         .di   (pix_in),
         .dout (rd[i])
      );
   end

   // RAM output registers are not reset, so taps stay zero until the first accept
   always_comb begin
      logic [LW-1:0] idx;
      idx          = '0;
      win_col      = '0;
      win_col[DW-1:0] = tap0;
      if (live) begin
         for (int unsigned k = 1; k <= M; k++) begin
            idx = LW'(tap_idx(32'(sel_line), k, M));
            win_col[k*DW +: DW] = rd[idx];
         end
      end
   end

endmodule

// File: tb/tb_line_window_buf.sv
// Scoreboard bench: three builds (N_LINES 2/3/5, IMG_W 8) fed the same directed pixel stream.
module tb_line_window_buf;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sof = 1'b0;
   logic       pix_valid = 1'b0;
   logic [7:0] pix_in = '0;

   logic        ov2, oe2, of2, ov3, oe3, of3, ov5, oe5, of5;
   logic [2:0]  oc2, oc3, oc5;
   logic [15:0] wc2;
   logic [23:0] wc3;
   logic [39:0] wc5;

   always #5 clk = ~clk;

   line_window_buf #(.DW(8), .IMG_W(8), .N_LINES(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
      .out_valid(ov2), .win_col(wc2), .out_col(oc2), .out_eol(oe2), .out_full(of2));
   line_window_buf #(.DW(8), .IMG_W(8), .N_LINES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
      .out_valid(ov3), .win_col(wc3), .out_col(oc3), .out_eol(oe3), .out_full(of3));
   line_window_buf #(.DW(8), .IMG_W(8), .N_LINES(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
      .out_valid(ov5), .win_col(wc5), .out_col(oc5), .out_eol(oe5), .out_full(of5));

   typedef struct {
      int              cyc;
      logic [2:0]      col;
      logic            eol;
      int              row;
      logic [7:0][7:0] taps;
   } exp_t;

   exp_t q2[$], q3[$], q5[$];
   exp_t e2, e3, e5;
   int   checks = 0, errors = 0, cyc = 0;
   int   mrow = 0, mcol = 0;
   logic [7:0] hist [8][8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic mon(input int n, input exp_t e, input logic [63:0] wc, input logic [2:0] oc,
                      input logic oe, input logic of);
      int depth;
      depth = (e.row < n - 1) ? e.row : n - 1;
      check($sformatf("N%0d latency", n), 64'(cyc), 64'(e.cyc));
      check($sformatf("N%0d out_col", n), 64'(oc), 64'(e.col));
      check($sformatf("N%0d out_eol col%0d", n, e.col), 64'(oe), 64'(e.eol));
      check($sformatf("N%0d out_full row%0d", n, e.row), 64'(of), 64'(e.row >= n - 1));
      for (int k = 0; k <= depth; k++)
         check($sformatf("N%0d row%0d col%0d tap%0d", n, e.row, e.col, k),
               64'(wc[k*8 +: 8]), 64'(e.taps[k]));
   endtask

   always @(negedge clk) if (ov2) begin
      check("N2 queue nonempty", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin e2 = q2.pop_front(); mon(2, e2, 64'(wc2), oc2, oe2, of2); end
   end
   always @(negedge clk) if (ov3) begin
      check("N3 queue nonempty", 64'(q3.size() > 0), 64'd1);
      if (q3.size() > 0) begin e3 = q3.pop_front(); mon(3, e3, 64'(wc3), oc3, oe3, of3); end
   end
   always @(negedge clk) if (ov5) begin
      check("N5 queue nonempty", 64'(q5.size() > 0), 64'd1);
      if (q5.size() > 0) begin e5 = q5.pop_front(); mon(5, e5, 64'(wc5), oc5, oe5, of5); end
   end

   // Pixel value 16*row+col within the current frame; taps k<=row are rows of this frame
   task automatic send(input logic s, input int gap, input logic idle_sof);
      exp_t e;
      @(negedge clk);
      if (s) begin mrow = 0; mcol = 0; end
      pix_in = 8'(16 * mrow + mcol);
      hist[mrow][mcol] = pix_in;
      e.cyc  = cyc + 1;
      e.col  = 3'(mcol);
      e.eol  = (mcol == 7);
      e.row  = mrow;
      e.taps = '0;
      for (int k = 0; k < 8; k++) if (k <= mrow) e.taps[k] = hist[mrow-k][mcol];
      pix_valid = 1'b1;
      sof       = s;
      q2.push_back(e); q3.push_back(e); q5.push_back(e);
      if (mcol == 7) begin mcol = 0; mrow++; end else mcol++;
      repeat (gap) begin
         @(negedge clk);
         pix_valid = 1'b0;
         sof       = idle_sof;
         pix_in    = 8'hEE;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_valid = 1'b0;
         sof       = 1'b0;
      end
   endtask

   task automatic zero_check(input string tag);
      check({tag, " N2 out_valid"}, 64'(ov2), 64'd0);
      check({tag, " N2 out_eol"},   64'(oe2), 64'd0);
      check({tag, " N2 out_full"},  64'(of2), 64'd0);
      check({tag, " N2 out_col"},   64'(oc2), 64'd0);
      check({tag, " N2 win_col"},   64'(wc2), 64'd0);
      check({tag, " N3 out_valid"}, 64'(ov3), 64'd0);
      check({tag, " N3 out_eol"},   64'(oe3), 64'd0);
      check({tag, " N3 out_full"},  64'(of3), 64'd0);
      check({tag, " N3 out_col"},   64'(oc3), 64'd0);
      check({tag, " N3 win_col"},   64'(wc3), 64'd0);
      check({tag, " N5 out_valid"}, 64'(ov5), 64'd0);
      check({tag, " N5 out_eol"},   64'(oe5), 64'd0);
      check({tag, " N5 out_full"},  64'(of5), 64'd0);
      check({tag, " N5 out_col"},   64'(oc5), 64'd0);
      check({tag, " N5 win_col"},   64'(wc5), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      zero_check("reset");
      rst_n = 1'b1;

      // frame A: six rows back to back
      for (int i = 0; i < 48; i++) send(i == 0, 0, 1'b0);
      idle(3);

      // frame B: 1-of-3 duty, sof held high while pix_valid is low
      for (int i = 0; i < 32; i++) send(i == 0, 2, 1'b1);
      idle(3);

      // frame C: sof arrives at row 2 col 4, then three fresh rows
      for (int i = 0; i < 20; i++) send(i == 0, 0, 1'b0);
      send(1'b1, 0, 1'b0);
      for (int i = 0; i < 23; i++) send(1'b0, 0, 1'b0);
      idle(2);

      // frame D: reset for one cycle at row 2 col 3 with a valid pixel present
      for (int i = 0; i < 19; i++) send(i == 0, 0, 1'b0);
      @(negedge clk);
      rst_n     = 1'b0;
      pix_valid = 1'b1;
      sof       = 1'b0;
      pix_in    = 8'h77;
      @(negedge clk);
      rst_n     = 1'b1;
      pix_valid = 1'b0;
      zero_check("mid-row reset");
      mrow = 0;
      mcol = 0;
      for (int i = 0; i < 32; i++) send(1'b0, 0, 1'b0);
      idle(4);

      check("N2 queue drained", 64'(q2.size()), 64'd0);
      check("N3 queue drained", 64'(q3.size()), 64'd0);
      check("N5 queue drained", 64'(q5.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
